srl_fifo_mc: RTL
================

# srl_fifo_mc

Multi-channel, parametrised SRL-backed FIFO for inter-PE streams in the quantised linear-layer datapath. It generalises the single-channel shift-register storage used in the `start_for` FIFOs to CHANNELS independent queues of arbitrary width and depth. Each channel adds an occupancy count, an almost-full flag and a synchronous flush. It sits between producer and consumer PEs (e.g. the i4xi4 pack stages) wherever several parallel lanes need matched buffering.

## Interface
- DATA_WIDTH, 32, bits per entry
- DEPTH, 16, entries per channel (≥2)
- CHANNELS, 2, independent queues (≥1)
- AF_MARGIN, 2, almost-full asserts when free slots ≤ AF_MARGIN (0 ≤ AF_MARGIN < DEPTH)
- CW (local), $clog2(DEPTH+1), count width

Ports (channel c occupies slice [c*W +: W] of each bus):
- ap_clk  in  1  sole clock, rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- if_write  in  CHANNELS  per-channel write request
- if_din  in  CHANNELS*DATA_WIDTH  write data
- if_full_n  out  CHANNELS  1 = channel can accept
- if_almost_full  out  CHANNELS  1 = count ≥ DEPTH−AF_MARGIN
- if_read  in  CHANNELS  per-channel read request
- if_dout  out  CHANNELS*DATA_WIDTH  head-of-queue data (first-word fall-through)
- if_empty_n  out  CHANNELS  1 = if_dout valid
- if_flush  in  CHANNELS  synchronous per-channel discard
- if_count  out  CHANNELS*CW  current occupancy

## Operation
- Per channel: push = if_write & if_full_n; pop = if_read & if_empty_n. Requests while blocked are ignored; no error state.
- Storage: DEPTH-entry shift register per channel. On push, all entries shift by one and the new word enters slot 0. Storage has no reset and no enable other than push.
- Read address = count−1 (oldest entry). if_dout is a combinational read of that slot, so the head is visible in the same cycle that if_empty_n=1.
- Count update: push only → +1; pop only → −1; push and pop → unchanged (shift plus address hold keeps the head correct); neither → unchanged.
- Flags are registered and derived from next-count:
  - if_empty_n = (count≠0)
  - if_full_n = (count≠DEPTH)
  - if_almost_full = (count ≥ DEPTH−AF_MARGIN)
- Full: push is blocked even when a pop occurs in the same cycle. The pop proceeds and count drops to DEPTH−1.
- Empty: pop is blocked. A push in the same cycle proceeds and count becomes 1.
- Flush: if_flush[c]=1 at an edge sets count=0 and restores the reset flag values. It overrides push and pop on that channel in that cycle. Stored data is not cleared.
- Channels are fully independent. Activity on one channel never alters another.
- Reset: asserting ap_rst_n low immediately, without waiting for a clock edge, sets every channel to count=0, if_empty_n=0, if_full_n=1, if_almost_full=0. Old data becomes unreachable. Deassertion is synchronised externally; the first push is accepted on the first edge with ap_rst_n=1.
- if_dout is undefined while if_empty_n=0 and must not be checked.

## Timing
- Write-to-read latency is 1 cycle: a push at edge t gives if_empty_n=1 with the word on if_dout after t.
- Back-to-back push and pop at 1 word/cycle per channel is sustained with no bubbles at any occupancy 1..DEPTH−1.
- All flag, count and data updates take effect at the same edge.
- The combinational path is if_read/count → if_dout only through registered count. There is no combinational path from if_write or if_read to any flag.

## Test plan
- Reset/fill/drain (DATA_WIDTH=8, DEPTH=4, CHANNELS=1):
  - After reset: empty_n=0, full_n=1, count=0.
  - Push 0x11,0x22,0x33,0x44 on 4 cycles → full_n=0, count=4, almost_full=1 from count=2.
  - Pop 4 → dout sequence 0x11..0x44, then empty_n=0.
- Full with simultaneous write and read: at count=4, drive write 0x55 and read together → 0x11 popped, 0x55 dropped, count=3. The next pop returns 0x22.
- Streaming: at count=2, write and read every cycle for 20 cycles with an incrementing pattern → count stays 2, in-order output, no loss.
- Flush priority: at count=3, assert flush+write+read on one cycle → count=0, empty_n=1→0 next cycle, the written word is discarded. The other channel's count is unchanged.
- Async reset mid-stream: at count=3, pull ap_rst_n low between edges → flags return to reset values before the next edge. After release, push 0xA5 → dout=0xA5.
- Channel isolation (CHANNELS=4): random independent push/pop per channel for 1000 cycles against a per-channel queue model → zero mismatches; count ≤ DEPTH always.

Source files
------------

// File: rtl/srl_fifo_mc_if.sv
// Handshake bundle for srl_fifo_mc: per-channel write/read/flush requests and
// the FIFO's status, count and head-of-queue data, each channel in its own slice.
interface srl_fifo_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int CW         = 5
);
    logic [CHANNELS-1:0]            if_write;
    logic [CHANNELS*DATA_WIDTH-1:0] if_din;
    logic [CHANNELS-1:0]            if_full_n;
    logic [CHANNELS-1:0]            if_almost_full;
    logic [CHANNELS-1:0]            if_read;
    logic [CHANNELS*DATA_WIDTH-1:0] if_dout;
    logic [CHANNELS-1:0]            if_empty_n;
    logic [CHANNELS-1:0]            if_flush;
    logic [CHANNELS*CW-1:0]         if_count;

    // Producer/consumer side.
    modport master (
        output if_write, if_din, if_read, if_flush,
        input  if_full_n, if_almost_full, if_dout, if_empty_n, if_count
    );

    // FIFO side.
    modport slave (
        input  if_write, if_din, if_read, if_flush,
        output if_full_n, if_almost_full, if_dout, if_empty_n, if_count
    );
endinterface

// File: rtl/srl_fifo_mc.sv
// Multi-channel shift-register FIFO: CHANNELS independent first-word-fall-through
// queues with registered flags, occupancy count and synchronous flush.
module srl_fifo_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int AF_MARGIN  = 2
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    srl_fifo_mc_if.slave fifo
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [CW-1:0]         count;
        logic [CW-1:0]         count_nxt;
        logic [AW-1:0]         rd_idx;
        logic                  empty_n;
        logic                  full_n;
        logic                  almost_full;
        logic                  push;
        logic                  pop;

        // Flush wins over both requests, so neither the shift nor the count moves.
        assign push = fifo.if_write[c] & full_n  & ~fifo.if_flush[c];
        assign pop  = fifo.if_read[c]  & empty_n & ~fifo.if_flush[c];

        // NOTE: storage is deliberately left out of reset; count alone decides what is valid.
        always_ff @(posedge ap_clk) begin
            if (push) begin
                mem[0] <= fifo.if_din[c*DATA_WIDTH +: DATA_WIDTH];
                for (int i = DEPTH - 1; i > 0; i--) begin
                    mem[i] <= mem[i-1];
                end
            end
        end

        // Oldest entry sits at count-1; simultaneous push/pop shifts it up while the address holds.
        assign rd_idx = AW'(count - 1'b1);
        assign fifo.if_dout[c*DATA_WIDTH +: DATA_WIDTH] = mem[rd_idx];

        // NOTE: default assignment first so every path assigns count_nxt and no latch is inferred.
        always_comb begin
            count_nxt = count;
            if (fifo.if_flush[c]) begin
                count_nxt = '0;
            end else if (push && !pop) begin
                count_nxt = count + 1'b1;
            end else if (pop && !push) begin
                count_nxt = count - 1'b1;
            end
        end

        // NOTE: non-blocking assignments keep all state updates on the same edge order-independent.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                count       <= '0;
                empty_n     <= 1'b0;
                full_n      <= 1'b1;
                almost_full <= 1'b0;
            end else begin
                count       <= count_nxt;
                empty_n     <= (count_nxt != '0);
                full_n      <= (count_nxt != CW'(DEPTH));
                almost_full <= (count_nxt >= CW'(DEPTH - AF_MARGIN));
            end
        end

        assign fifo.if_empty_n[c]          = empty_n;
        assign fifo.if_full_n[c]           = full_n;
        assign fifo.if_almost_full[c]      = almost_full;
        assign fifo.if_count[c*CW +: CW]   = count;
    end
endmodule
